// File: rtl/soc_sram_sp_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Supports counter-bounded locked bursts and returns read data to the issuing port.
module soc_sram_sp_arbiter #(
  parameter int WORD_AW   = 30,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic               lock0,
  input  logic               lock1,
  input  logic [WORD_AW-1:0] addr0,
  input  logic [WORD_AW-1:0] addr1,
  input  logic [DW-1:0]      wdata0,
  input  logic [DW-1:0]      wdata1,
  input  logic [DW/8-1:0]    sel0,
  input  logic [DW/8-1:0]    sel1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               ack0,
  output logic               ack1,
  output logic [DW-1:0]      rdata0,
  output logic [DW-1:0]      rdata1,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [DW-1:0]      sram_din,
  output logic [DW/8-1:0]    sram_sel,
  input  logic [DW-1:0]      sram_dout
);

  localparam int SW = DW / 8;

  logic       last_ptr;
  logic       owner_vld;
  logic       owner;
  logic [7:0] burst_cnt;
  logic       resp_valid;
  logic       resp_port;
  logic       resp_is_read;

  logic       gnt_any;
  logic       gport;
  logic       g_we;
  logic       g_lock;
  logic [7:0] base_cnt;
  logic [8:0] next_cnt;
  logic       keep_lock;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_any = 1'b0;
    gport   = 1'b0;
    if (!rst) begin
      gnt_any = 1'b0;
    end else if (owner_vld && (owner ? req1 : req0)) begin
      gnt_any = 1'b1;
      gport   = owner;
    end else if (req0 && req1) begin
      gnt_any = 1'b1;
      gport   = ~last_ptr;
    end else if (req0) begin
      gnt_any = 1'b1;
      gport   = 1'b0;
    end else if (req1) begin
      gnt_any = 1'b1;
      gport   = 1'b1;
    end
  end

  assign gnt0   = gnt_any & ~gport;
  assign gnt1   = gnt_any & gport;
  assign g_we   = gport ? we1 : we0;
  assign g_lock = gport ? lock1 : lock0;

  // Burst count only carries over while the same port keeps the lock.
  assign base_cnt  = (owner_vld && (owner == gport)) ? burst_cnt : 8'd0;
  assign next_cnt  = {1'b0, base_cnt} + 9'd1;
  assign keep_lock = g_lock && (next_cnt < 9'(MAX_BURST));

  // SRAM writes on we alone, so every control is qualified by the grant.
  assign sram_ce    = gnt_any;
  assign sram_we    = gnt_any & g_we;
  assign sram_oe    = gnt_any & ~g_we;
  assign sram_waddr = gnt_any ? (gport ? addr1 : addr0) : '0;
  assign sram_din   = gnt_any ? (gport ? wdata1 : wdata0) : '0;
  assign sram_sel   = gnt_any ? (gport ? sel1 : sel0) : {SW{1'b0}};

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ptr     <= 1'b1;
      owner_vld    <= 1'b0;
      owner        <= 1'b0;
      burst_cnt    <= 8'd0;
      resp_valid   <= 1'b0;
      resp_port    <= 1'b0;
      resp_is_read <= 1'b0;
    end else begin
      resp_valid <= gnt_any;
      if (gnt_any) begin
        last_ptr     <= gport;
        resp_port    <= gport;
        resp_is_read <= ~g_we;
        if (keep_lock) begin
          owner_vld <= 1'b1;
          owner     <= gport;
          burst_cnt <= next_cnt[7:0];
        end else begin
          owner_vld <= 1'b0;
          burst_cnt <= 8'd0;
        end
      end else if (owner_vld) begin
        owner_vld <= 1'b0;
        burst_cnt <= 8'd0;
      end
    end
  end

  assign ack0   = resp_valid & ~resp_port;
  assign ack1   = resp_valid & resp_port;
  assign rdata0 = (ack0 && resp_is_read) ? sram_dout : '0;
  assign rdata1 = (ack1 && resp_is_read) ? sram_dout : '0;

endmodule
